add_tree_arbiter: RTL
=====================

# add_tree_arbiter

Round-robin arbiter that shares one pipelined adder tree (`add_tree`, latency clog2(INPUTS)) between REQS requesters. Each requester offers a vector of INPUTS operands with a valid/ready handshake. The block grants one requester per cycle, feeds its vector into the tree, and tracks the requester index (tag) alongside the tree pipeline. It presents each sum with its tag on a single result stream with backpressure. It sits between several accumulation clients and a single shared summation resource.

## Interface
Parameters:
- WIDTH, 8, operand width in bits.
- INPUTS, 5, operands per request. Must be ≥ 2.
- REQS, 4, number of requesters. Must be ≥ 2.
- Derived (localparam): LAT = $clog2(INPUTS), tree latency.
- Derived (localparam): TW = $clog2(REQS), tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  [REQS]  request valid, one bit per requester.
- req_ready  out  [REQS]  request accepted this cycle, one-hot or zero.
- req_signed  in  [REQS]  operands of requester r are two's complement.
- req_data  in  [REQS][INPUTS][WIDTH]  operand vectors.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_tag  out  TW  index of the requester that owns the result.
- res_signed  out  1  signedness of the result.
- res_data  out  WIDTH+LAT  sum of the INPUTS operands.

## Operation
- advance = ~res_valid | res_ready.
  - advance drives the tree clkena and enables the valid/tag shift register, which is LAT stages deep.
  - The whole pipe stalls as one; bubbles are not squeezed out.
- Grant is combinational.
  - When advance=1, select the first requester with req_valid=1, searching from pointer ptr upward with wrap-around.
  - req_ready[g]=1 for the granted requester only.
  - When advance=0 or reset=1, req_ready is all zeros.
- Transfer happens when req_valid[g] & req_ready[g]. In that case:
  - tree input = req_data[g], i_signed = req_signed[g];
  - stage-0 valid = 1, stage-0 tag = g;
  - ptr <= (g+1) mod REQS.
- No transfer on an advancing cycle:
  - tree input is forced to zero, i_signed = 0;
  - stage-0 valid = 0;
  - ptr is unchanged.
- Result mapping:
  - res_valid, res_tag = last stage of the shift register;
  - res_data, res_signed = tree outputs.
- Signedness:
  - signed requests are sign-extended at every tree level;
  - unsigned requests are zero-extended;
  - results never overflow WIDTH+LAT bits.
- Results leave in acceptance order.
- Holding a result: while res_valid=1 and res_ready=0, res_* are held stable and no request is accepted.
- Requesters may drop req_valid without a handshake. The block is fair only between requesters that hold req_valid until accepted.
- Reset (asynchronous, allowed mid-operation):
  - all in-flight results are discarded;
  - ptr = 0;
  - the shift register and tree registers clear.

## Timing
- Reset values: res_valid=0, res_tag=0, res_signed=0, res_data=0, req_ready=0.
- Latency: a request accepted in cycle t gives res_valid=1 in cycle t+LAT, provided advance=1 in every cycle in between. For INPUTS=5, LAT=3.
- Throughput: one request per cycle while res_ready=1.
- Result handshake: res_valid=1 & res_ready=1 at a rising edge consumes the result. A request may be accepted in the same cycle (advance=1).
- First cycle after reset deassertion: requests are accepted with ptr=0.

## Configuration
- Macro: ADD_TREE_ARBITER_RR_EN.
- Defined: round-robin grant as described above, with starvation bound of REQS-1 grants to other requesters.
- Undefined:
  - fixed priority, lowest index wins;
  - ptr register is not implemented and is treated as constant 0;
  - all other behaviour is identical.

## Test plan
1. Single request: req_valid[2]=1 with unsigned data {1,2,3,4,5}, WIDTH=8, INPUTS=5, res_ready=1.
   -> req_ready[2]=1 for one cycle.
   -> Three cycles later: res_valid=1, res_tag=2, res_data=15, res_signed=0.
2. Signed extremes: req_signed[0]=1 with data {-128 ×5}.
   -> res_data=-640 (11'h580), res_signed=1.
   -> The same bits sent unsigned give 640.
3. Round-robin, all four requesters valid continuously.
   -> Grants 0,1,2,3,0,… one per cycle.
   -> res_tag sequence is 0,1,2,3 starting 3 cycles after the first grant.
   -> With ADD_TREE_ARBITER_RR_EN undefined: grants 0,0,0,…
4. Backpressure:
   - Stimulus: hold res_ready=0 for 5 cycles with a full pipe.
   -> res_* remain stable and req_ready=0 throughout.
   - Stimulus: then release res_ready.
   -> Results resume in order with no loss or duplication.
5. Bubbles: requests in cycles 0 and 2 only.
   -> res_valid=1 in cycles 3 and 5, 0 in cycle 4.
6. Mid-operation reset: assert reset with 3 results in flight.
   -> Immediately res_valid=0, req_ready=0.
   -> After release, no stale result appears and the first grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/add_tree_arbiter.sv
// Round-robin arbiter sharing one pipelined adder tree between REQS requesters.
// Define ADD_TREE_ARBITER_RR_EN for round-robin; otherwise lowest index wins.

module add_tree #(
   parameter int WIDTH  = 8,
   parameter int INPUTS = 5,
   localparam int LAT   = $clog2(INPUTS),
   localparam int OW    = WIDTH + LAT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clkena,
   input  logic                      i_signed,
   input  logic [INPUTS*WIDTH-1:0]   i_data,
   output logic                      o_signed,
   output logic [OW-1:0]             o_data
);

   function automatic int nodes(input int lvl);
      return (INPUTS + (1 << lvl) - 1) >> lvl;
   endfunction

   function automatic int clampi(input int k);
      return (k < INPUTS) ? k : INPUTS - 1;
   endfunction

   logic [OW-1:0] lv0 [INPUTS];
   logic [OW-1:0] lv  [1:LAT][INPUTS];
   logic          sg  [1:LAT];

   // Extending to the full output width up front equals per-level extension,
   // since the final sum never exceeds OW bits.
   always_comb begin
      for (int i = 0; i < INPUTS; i++) begin
         lv0[i] = {{LAT{i_signed & i_data[i*WIDTH+WIDTH-1]}},
                   i_data[i*WIDTH +: WIDTH]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 1; l <= LAT; l++) begin
            sg[l] <= 1'b0;
            for (int j = 0; j < INPUTS; j++) lv[l][j] <= '0;
         end
      end else if (clkena) begin
         sg[1] <= i_signed;
         for (int j = 0; j < INPUTS; j++) begin
            if (j >= nodes(1))
               lv[1][j] <= '0;
            else if (2*j+1 < INPUTS)
               lv[1][j] <= lv0[clampi(2*j)] + lv0[clampi(2*j+1)];
            else
               lv[1][j] <= lv0[clampi(2*j)];
         end
         for (int l = 2; l <= LAT; l++) begin
            sg[l] <= sg[l-1];
            for (int j = 0; j < INPUTS; j++) begin
               if (j >= nodes(l))
                  lv[l][j] <= '0;
               else if (2*j+1 < nodes(l-1))
                  lv[l][j] <= lv[l-1][clampi(2*j)] + lv[l-1][clampi(2*j+1)];
               else
                  lv[l][j] <= lv[l-1][clampi(2*j)];
            end
         end
      end
   end

   assign o_signed = sg[LAT];
   assign o_data   = lv[LAT][0];

endmodule

module add_tree_arbiter #(
   parameter int WIDTH  = 8,
   parameter int INPUTS = 5,
   parameter int REQS   = 4,
   localparam int LAT   = $clog2(INPUTS),
   localparam int TW    = $clog2(REQS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [REQS-1:0]                 req_valid,
   output logic [REQS-1:0]                 req_ready,
   input  logic [REQS-1:0]                 req_signed,
   input  logic [REQS*INPUTS*WIDTH-1:0]    req_data,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [TW-1:0]                   res_tag,
   output logic                            res_signed,
   output logic [WIDTH+LAT-1:0]            res_data
);

   localparam int VW = INPUTS * WIDTH;

   logic            advance;
   logic            found;
   logic            xfer;
   logic [TW-1:0]   gnt;
   logic [TW-1:0]   ptr;
   logic [VW-1:0]   tin;
   logic            tsg;
   logic            vld [1:LAT];
   logic [TW-1:0]   tg  [1:LAT];

   assign advance = ~res_valid | res_ready;

   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      gnt   = '0;
      for (int k = 0; k < REQS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= REQS) idx = idx - REQS;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = TW'(idx);
         end
      end
   end

   assign xfer      = advance & found & ~reset;
   assign req_ready = xfer ? ({{(REQS-1){1'b0}}, 1'b1} << gnt) : '0;
   assign tin       = xfer ? req_data[gnt*VW +: VW] : '0;
   assign tsg       = xfer & req_signed[gnt];

`ifdef ADD_TREE_ARBITER_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (xfer)
         ptr <= (gnt == TW'(REQS-1)) ? '0 : gnt + 1'b1;
   end
`else
   assign ptr = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 1; l <= LAT; l++) begin
            vld[l] <= 1'b0;
            tg[l]  <= '0;
         end
      end else if (advance) begin
         vld[1] <= xfer;
         tg[1]  <= xfer ? gnt : '0;
         for (int l = 2; l <= LAT; l++) begin
            vld[l] <= vld[l-1];
            tg[l]  <= tg[l-1];
         end
      end
   end

   assign res_valid = vld[LAT];
   assign res_tag   = tg[LAT];

   add_tree #(
      .WIDTH  (WIDTH),
      .INPUTS (INPUTS)
   ) u_tree (
      .clk      (clk),
      .reset    (reset),
      .clkena   (advance),
      .i_signed (tsg),
      .i_data   (tin),
      .o_signed (res_signed),
      .o_data   (res_data)
   );

endmodule
